// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi: enables, divisor write port, divided outputs.
// Latency: none (wires only); all outputs are registered inside the divider.
// Backpressure: none; divisor writes are single-cycle strobes that are always accepted.
// The sync realignment strobe exists only when CLK_DIV_SYNC_EN is defined.
interface clk_div_multi_if #(
  parameter int N_CH = 4,
  parameter int CW   = 32
);
  logic [N_CH-1:0]    en;
  logic               wr_en;
  logic [3:0]         wr_ch;
  logic [CW-1:0]      wr_data;
`ifdef CLK_DIV_SYNC_EN
  logic               sync;
`endif
  logic [N_CH-1:0]    clk_out;
  logic [N_CH-1:0]    tick;
  logic [N_CH*CW-1:0] div_act;

`ifdef CLK_DIV_SYNC_EN
  modport master (
    output en, wr_en, wr_ch, wr_data, sync,
    input  clk_out, tick, div_act
  );
  modport slave (
    input  en, wr_en, wr_ch, wr_data, sync,
    output clk_out, tick, div_act
  );
`else
  modport master (
    output en, wr_en, wr_ch, wr_data,
    input  clk_out, tick, div_act
  );
  modport slave (
    input  en, wr_en, wr_ch, wr_data,
    output clk_out, tick, div_act
  );
`endif
endinterface

// File: rtl/clk_div_multi.sv
// N-channel programmable tick/clock divider with shadowed runtime divisors.
// Latency: outputs registered; first tick E cycles after the first enabled edge.
// Backpressure: none; divisor writes always land in the shadow, applied at wrap or when idle.
// Optional feature macro: CLK_DIV_SYNC_EN adds a sync strobe that realigns all enabled channels.
// The interface instance must be built with the same N_CH/CW as this module.
module clk_div_multi #(
  parameter int          N_CH        = 4,
  parameter int          CW          = 32,
  parameter int unsigned DEFAULT_DIV = 700_000
) (
  input logic            clk,
  input logic            reset,
  clk_div_multi_if.slave bus
);

  localparam logic [CW-1:0] DEF_DIV = CW'(DEFAULT_DIV);

  // Per-channel state: period counter, active divisor, pending (shadow) divisor.
  logic [CW-1:0]   cnt_q    [N_CH];
  logic [CW-1:0]   cnt_d    [N_CH];
  logic [CW-1:0]   act_q    [N_CH];
  logic [CW-1:0]   act_d    [N_CH];
  logic [CW-1:0]   shd_q    [N_CH];
  logic [CW-1:0]   shd_d    [N_CH];
  logic [CW-1:0]   last_cnt [N_CH];

  logic [N_CH-1:0] clk_out_q;
  logic [N_CH-1:0] clk_out_d;
  logic [N_CH-1:0] tick_q;
  logic [N_CH-1:0] tick_d;
  logic [N_CH-1:0] wr_hit;
  logic [N_CH-1:0] wrap;
  logic [N_CH-1:0] realign;
  logic            sync_req;

`ifdef CLK_DIV_SYNC_EN
  assign sync_req = bus.sync;
`else
  assign sync_req = 1'b0;
`endif

  // Decode the write strobe to one channel; wr_ch beyond N_CH matches nothing and is dropped.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i] = bus.wr_en && ({1'b0, bus.wr_ch} == 5'(i));
      // A same-edge write overrides the stale shadow for anything that loads active this edge.
      shd_d[i]  = wr_hit[i] ? bus.wr_data : shd_q[i];
    end
  end

  // Per-channel next state: idle/realign clears the phase, wrap ends a period, else count on.
  always_comb begin
    wrap      = '0;
    realign   = '0;
    tick_d    = '0;
    clk_out_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      // Divisor 0 behaves as 1, so both give a terminal count of 0.
      last_cnt[i] = (act_q[i] == '0) ? '0 : act_q[i] - CW'(1);
      cnt_d[i]    = cnt_q[i];
      act_d[i]    = act_q[i];
      realign[i]  = !bus.en[i] || sync_req;
      wrap[i]     = bus.en[i] && (cnt_q[i] == last_cnt[i]);
      if (realign[i]) begin
        cnt_d[i]     = '0;
        tick_d[i]    = 1'b0;
        clk_out_d[i] = 1'b0;
        act_d[i]     = shd_d[i];
      end else if (wrap[i]) begin
        // The period just finished used the old divisor; the new one starts with cnt at 0.
        cnt_d[i]     = '0;
        tick_d[i]    = 1'b1;
        clk_out_d[i] = ~clk_out_q[i];
        act_d[i]     = shd_d[i];
      end else begin
        cnt_d[i]     = cnt_q[i] + CW'(1);
        tick_d[i]    = 1'b0;
        clk_out_d[i] = clk_out_q[i];
      end
    end
  end

  // State registers; synchronous reset restores the default divisor and drops pending writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= DEF_DIV;
        shd_q[i] <= DEF_DIV;
      end
      clk_out_q <= '0;
      tick_q    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        act_q[i] <= act_d[i];
        shd_q[i] <= shd_d[i];
      end
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_div_act
    assign bus.div_act[g*CW +: CW] = act_q[g];
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus randomized traffic.
// Outputs sampled on negedge; inputs driven on negedge.
// Reference model tracks elapsed cycles per period and divisor hand-off per channel.
module tb_clk_div_multi;

  localparam int          N_CH = 4;
  localparam int          CW   = 16;
  localparam int unsigned DEF  = 5;

  logic clk = 1'b0;
  logic reset;

  clk_div_multi_if #(.N_CH(N_CH), .CW(CW)) bus ();

  clk_div_multi #(
    .N_CH(N_CH),
    .CW(CW),
    .DEFAULT_DIV(DEF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Reference model state.
  logic [CW-1:0]   m_shadow [N_CH];
  logic [CW-1:0]   m_active [N_CH];
  int              m_elapsed[N_CH];
  logic [N_CH-1:0] m_clk;
  logic [N_CH-1:0] m_tick;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each enabled channel counts elapsed cycles; a period ends after E of them.
  always @(posedge clk) begin
    logic          s;
    logic [CW-1:0] nsh;
    int            e;
    s = 1'b0;
`ifdef CLK_DIV_SYNC_EN
    s = bus.sync;
`endif
    for (int i = 0; i < N_CH; i++) begin
      if (reset) begin
        m_shadow[i]  = CW'(DEF);
        m_active[i]  = CW'(DEF);
        m_elapsed[i] = 0;
        m_clk[i]     = 1'b0;
        m_tick[i]    = 1'b0;
      end else begin
        nsh = (bus.wr_en && bus.wr_ch == 4'(i)) ? bus.wr_data : m_shadow[i];
        e   = (m_active[i] == '0) ? 1 : int'(m_active[i]);
        if (!bus.en[i] || s) begin
          m_elapsed[i] = 0;
          m_tick[i]    = 1'b0;
          m_clk[i]     = 1'b0;
          m_active[i]  = nsh;
        end else begin
          m_elapsed[i] = m_elapsed[i] + 1;
          if (m_elapsed[i] == e) begin
            m_elapsed[i] = 0;
            m_tick[i]    = 1'b1;
            m_clk[i]     = ~m_clk[i];
            m_active[i]  = nsh;
          end else begin
            m_tick[i]    = 1'b0;
          end
        end
        m_shadow[i] = nsh;
      end
    end
  end

  // Compare DUT against the model every cycle once reset has been applied.
  always @(negedge clk) begin
    logic [N_CH*CW-1:0] ed;
    if (chk_on) begin
      for (int i = 0; i < N_CH; i++) ed[i*CW +: CW] = m_active[i];
      check("model_clk_out", 64'(bus.clk_out), 64'(m_clk));
      check("model_tick",    64'(bus.tick),    64'(m_tick));
      check("model_div_act", 64'(bus.div_act), 64'(ed));
    end
  end

  initial begin
    logic [N_CH-1:0] exp_t;
    logic [N_CH-1:0] exp_c;
    logic            lvl;

    reset        = 1'b1;
    bus.en       = '0;
    bus.wr_en    = 1'b0;
    bus.wr_ch    = '0;
    bus.wr_data  = '0;
`ifdef CLK_DIV_SYNC_EN
    bus.sync     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    check("reset_tick",    64'(bus.tick),    64'h0);
    check("reset_clk_out", 64'(bus.clk_out), 64'h0);
    check("reset_div_act", 64'(bus.div_act), 64'h0005_0005_0005_0005);

    // Default divisor 5 on ch0 only.
    reset  = 1'b0;
    bus.en = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_t = {3'b000, (k % 5) == 0};
      exp_c = {3'b000, (k >= 5 && k < 10)};
      check("t1_tick",    64'(bus.tick),    64'(exp_t));
      check("t1_clk_out", 64'(bus.clk_out), 64'(exp_c));
    end

    // Shrink ch0 from 5 to 3 mid-period (cnt=2); current period still lasts 5.
    repeat (2) @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 4'd0;
    bus.wr_data = 16'd3;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("t2_div_after_write", 64'(bus.div_act[15:0]), 64'd5);
    @(negedge clk);
    check("t2_no_early_tick", 64'(bus.tick[0]),        64'd0);
    check("t2_div_hold",      64'(bus.div_act[15:0]), 64'd5);
    @(negedge clk);
    check("t2_wrap_tick",     64'(bus.tick[0]),        64'd1);
    check("t2_div_switched",  64'(bus.div_act[15:0]), 64'd3);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("t2_period3_tick", 64'(bus.tick[0]), 64'((k % 3) == 0));
    end

    // ch1 divisor 0 then 1: tick held high, clk_out toggling every cycle.
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 4'd1;
    bus.wr_data = 16'd0;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.en    = 4'b0011;
    lvl       = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = 16'd1;
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
      lvl       = ~lvl;
      check("t3_tick_const", 64'(bus.tick[1]),    64'd1);
      check("t3_clk_toggle", 64'(bus.clk_out[1]), 64'(lvl));
    end
    check("t3_div1", 64'(bus.div_act[31:16]), 64'd1);

    // Out-of-range channel write changes nothing.
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 4'd9;
    bus.wr_data = 16'd7;
    @(negedge clk);
    bus.wr_en = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_div_unchanged", 64'(bus.div_act), 64'h0005_0005_0001_0003);

    // Reset mid-period at cnt=3 of divisor 5.
    bus.en      = 4'b0000;
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 4'd0;
    bus.wr_data = 16'd5;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.en    = 4'b0001;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_reset_tick",    64'(bus.tick),    64'h0);
    check("t5_reset_clk_out", 64'(bus.clk_out), 64'h0);
    check("t5_reset_div",     64'(bus.div_act), 64'h0005_0005_0005_0005);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("t5_first_tick", 64'(bus.tick[0]), 64'(k == 5));
    end

`ifdef CLK_DIV_SYNC_EN
    // Realign ch0 (div 4) and ch1 (div 6) from a random phase.
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 4'd0;
    bus.wr_data = 16'd4;
    @(negedge clk);
    bus.wr_ch   = 4'd1;
    bus.wr_data = 16'd6;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.en    = 4'b0011;
    repeat ($urandom_range(10, 30)) @(negedge clk);
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
    check("t6_sync_clk_out", 64'(bus.clk_out[1:0]), 64'd0);
    check("t6_sync_tick",    64'(bus.tick[1:0]),    64'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_t = {2'b00, (k % 6) == 0, (k % 4) == 0};
      check("t6_aligned_ticks", 64'(bus.tick), 64'(exp_t));
    end
`endif

    // Randomized traffic checked against the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 15) == 0) bus.en = 4'($urandom);
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_ch   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      bus.wr_data = 16'($urandom_range(0, 9));
`ifdef CLK_DIV_SYNC_EN
      bus.sync    = ($urandom_range(0, 49) == 0);
`endif
    end
    @(negedge clk);
    reset     = 1'b0;
    bus.wr_en = 1'b0;
`ifdef CLK_DIV_SYNC_EN
    bus.sync  = 1'b0;
`endif
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
